// File: rtl/ftdi_rx_packer.sv
// Purpose : FTDI sync-245 read master; packs received bytes little-endian into IQ_DATA_WIDTH words.
// Latency : last byte of a word sampled at edge N -> f2a_data_o/f2a_we_o updated at edge N+1.
// Backpressure: full_i stops new reads (slack covers in-flight bytes); words are never dropped or stalled.
//
// Ports:
//   clk_i, rst_n_i          FTDI CLKOUT and asynchronous active-low reset
//   ftdi_data_i/_rxf_n_i    FTDI data bus and RX-available flag (active low)
//   ftdi_oe_n_o/_rd_n_o     FTDI output-enable and read strobe (active low, registered)
//   full_i, resync_i        downstream almost-full, one-cycle realign pulse
//   f2a_data_o/_we_o        assembled word and its one-cycle write strobe
//   word_cnt_o              free-running count of emitted words
module ftdi_rx_packer #(
  parameter int IQ_DATA_WIDTH = 24,
  parameter int BYTE_W        = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [BYTE_W-1:0]        ftdi_data_i,
  input  logic                     ftdi_rxf_n_i,
  output logic                     ftdi_oe_n_o,
  output logic                     ftdi_rd_n_o,
  input  logic                     full_i,
  input  logic                     resync_i,
  output logic [IQ_DATA_WIDTH-1:0] f2a_data_o,
  output logic                     f2a_we_o,
  output logic [15:0]              word_cnt_o
);

  localparam int BYTES_PER_WORD = IQ_DATA_WIDTH / BYTE_W;
  localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    READ = 2'd2
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         byte_idx;
  logic [IQ_DATA_WIDTH-1:0] partial;
  logic                     word_done;  // partial holds a complete word, publish next edge

  logic                     accept;
  logic [IDX_W-1:0]         idx_eff;
  logic [IQ_DATA_WIDTH-1:0] word_next;

  // rd_n is low exactly while in READ, so a byte is taken whenever READ sees RXF# low,
  // including the cycle in which the exit condition is sampled.
  assign accept = (state == READ) && !ftdi_rxf_n_i;

  // A resync coincident with an accepted byte makes that byte byte 0 of a fresh word.
  // Starting a word at index 0 also clears the bytes left over from the previous word.
  always_comb begin
    idx_eff   = resync_i ? '0 : byte_idx;
    word_next = (idx_eff == '0) ? '0 : partial;
    word_next[int'(idx_eff)*BYTE_W +: BYTE_W] = ftdi_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      ftdi_oe_n_o <= 1'b1;
      ftdi_rd_n_o <= 1'b1;
      byte_idx    <= '0;
      partial     <= '0;
      word_done   <= 1'b0;
      f2a_data_o  <= '0;
      f2a_we_o    <= 1'b0;
      word_cnt_o  <= '0;
    end else begin
      // Read handshake: OE# leads RD# by one turnaround cycle.
      case (state)
        IDLE: begin
          if (!ftdi_rxf_n_i && !full_i) begin
            state       <= TURN;
            ftdi_oe_n_o <= 1'b0;
          end
        end
        TURN: begin
          state       <= READ;
          ftdi_rd_n_o <= 1'b0;
        end
        READ: begin
          if (ftdi_rxf_n_i || full_i) begin
            state       <= IDLE;
            ftdi_oe_n_o <= 1'b1;
            ftdi_rd_n_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          ftdi_oe_n_o <= 1'b1;
          ftdi_rd_n_o <= 1'b1;
        end
      endcase

      // Word publication, one edge after the last byte landed in partial.
      f2a_we_o <= word_done;
      if (word_done) begin
        f2a_data_o <= partial;
        word_cnt_o <= word_cnt_o + 16'd1;
      end

      // Byte packing; index and partial survive IDLE/TURN pauses.
      word_done <= 1'b0;
      if (accept) begin
        partial <= word_next;
        if (idx_eff == LAST_IDX) begin
          byte_idx  <= '0;
          word_done <= 1'b1;
        end else begin
          byte_idx <= idx_eff + 1'b1;
        end
      end else if (resync_i) begin
        byte_idx <= '0;
        partial  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ftdi_rx_packer.sv
// Purpose : self-checking bench for ftdi_rx_packer; acts as the FTDI device and scores words.
// Latency : model expects each word strobe one edge after its last byte was read.
// Backpressure: exercises full_i blocking, RXF# pauses, resync, async reset and counter wrap.
module tb_ftdi_rx_packer;

  localparam int BPW = 3;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  ftdi_data_i = 8'h00;
  logic        ftdi_rxf_n_i = 1'b1;
  logic        ftdi_oe_n_o;
  logic        ftdi_rd_n_o;
  logic        full_i = 1'b0;
  logic        resync_i = 1'b0;
  logic [23:0] f2a_data_o;
  logic        f2a_we_o;
  logic [15:0] word_cnt_o;

  // Byte-wide instance, used for the 65536-word wrap run (one word per byte).
  logic [7:0]  w_data = 8'h00;
  logic        w_rxf_n = 1'b1;
  logic        w_oe_n;
  logic        w_rd_n;
  logic [7:0]  w_f2a_data;
  logic        w_we;
  logic [15:0] w_cnt;

  always #5 clk_i = ~clk_i;

  ftdi_rx_packer dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ftdi_data_i(ftdi_data_i), .ftdi_rxf_n_i(ftdi_rxf_n_i),
    .ftdi_oe_n_o(ftdi_oe_n_o), .ftdi_rd_n_o(ftdi_rd_n_o), .full_i(full_i), .resync_i(resync_i),
    .f2a_data_o(f2a_data_o), .f2a_we_o(f2a_we_o), .word_cnt_o(word_cnt_o)
  );

  ftdi_rx_packer #(.IQ_DATA_WIDTH(8), .BYTE_W(8)) dut_w8 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ftdi_data_i(w_data), .ftdi_rxf_n_i(w_rxf_n),
    .ftdi_oe_n_o(w_oe_n), .ftdi_rd_n_o(w_rd_n), .full_i(1'b0), .resync_i(1'b0),
    .f2a_data_o(w_f2a_data), .f2a_we_o(w_we), .word_cnt_o(w_cnt)
  );

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [7:0]  src[$];     // bytes the FTDI still has to deliver
  logic [7:0]  pend[$];    // bytes read into the current, incomplete word
  logic [23:0] exp_q[$];   // completed words awaiting their strobe
  logic [23:0] got_q[$];   // words observed on the output
  int          we_cyc[$];
  logic        we_due = 1'b0;
  logic [15:0] mcnt = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: present the FTDI bus, predict acceptance, advance, score the result.
  task automatic tick();
    logic        acc;
    logic        done_now;
    logic [23:0] w;
    ftdi_data_i  = (src.size() != 0) ? src[0] : 8'h00;
    ftdi_rxf_n_i = (src.size() == 0);
    acc      = (ftdi_rd_n_o === 1'b0) && (ftdi_rxf_n_i === 1'b0);
    done_now = 1'b0;
    if (resync_i) pend.delete();
    if (acc) begin
      pend.push_back(ftdi_data_i);
      if (pend.size() == BPW) begin
        w = '0;
        for (int k = 0; k < BPW; k++) w = w | (24'(pend[k]) << (8 * k));
        exp_q.push_back(w);
        pend.delete();
        done_now = 1'b1;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    chk("we", 32'(f2a_we_o), 32'(we_due));
    if (f2a_we_o === 1'b1) begin
      got_q.push_back(f2a_data_o);
      we_cyc.push_back(cyc);
    end
    if (we_due && exp_q.size() != 0) begin
      chk("data", 32'(f2a_data_o), 32'(exp_q.pop_front()));
      mcnt++;
      chk("cnt", 32'(word_cnt_o), 32'(mcnt));
    end
    we_due = done_now;
    if (acc) void'(src.pop_front());
    resync_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && src.size() != 0; i++) tick();
    chk("drain", src.size(), 0);
    repeat (4) tick();
  endtask

  task automatic wait_pend(input int n, input string tag);
    for (int i = 0; i < 20 && pend.size() != n; i++) tick();
    chk(tag, pend.size(), n);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    src.push_back(a); src.push_back(b); src.push_back(c);
  endtask

  initial begin
    int sent;
    int seen;
    logic acc;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_oe", 32'(ftdi_oe_n_o), 1);
    chk("rst_rd", 32'(ftdi_rd_n_o), 1);
    chk("rst_data", 32'(f2a_data_o), 0);
    chk("rst_we", 32'(f2a_we_o), 0);
    chk("rst_cnt", 32'(word_cnt_o), 0);
    rst_n_i = 1'b1;
    tick();

    // 1: back-to-back stream of two words
    push3(8'h11, 8'h22, 8'h33);
    push3(8'h44, 8'h55, 8'h66);
    got_q.delete(); we_cyc.delete();
    tick();
    chk("t1_turn_oe", 32'(ftdi_oe_n_o), 0);
    chk("t1_turn_rd", 32'(ftdi_rd_n_o), 1);
    tick();
    chk("t1_read_rd", 32'(ftdi_rd_n_o), 0);
    drain();
    chk("t1_nwords", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t1_w0", 32'(got_q[0]), 32'h332211);
      chk("t1_w1", 32'(got_q[1]), 32'h665544);
      chk("t1_gap", we_cyc[1] - we_cyc[0], 3);
    end
    chk("t1_cnt", 32'(word_cnt_o), 2);

    // 2: RXF# pause mid-word
    got_q.delete();
    src.push_back(8'hAA); src.push_back(8'hBB);
    drain();
    chk("t2_nostrobe", got_q.size(), 0);
    chk("t2_oe_idle", 32'(ftdi_oe_n_o), 1);
    chk("t2_rd_idle", 32'(ftdi_rd_n_o), 1);
    src.push_back(8'hCC);
    tick();
    chk("t2_turn_oe", 32'(ftdi_oe_n_o), 0);
    chk("t2_turn_rd", 32'(ftdi_rd_n_o), 1);
    drain();
    chk("t2_nwords", got_q.size(), 1);
    if (got_q.size() == 1) chk("t2_w", 32'(got_q[0]), 32'hCCBBAA);

    // 3: full_i raised while byte 1 of a word is being read
    got_q.delete();
    push3(8'h31, 8'h32, 8'h33);
    push3(8'h34, 8'h35, 8'h36);
    wait_pend(1, "t3_reach");
    full_i = 1'b1;
    tick();
    chk("t3_rd_drop", 32'(ftdi_rd_n_o), 1);
    chk("t3_oe_drop", 32'(ftdi_oe_n_o), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_blocked", 32'(ftdi_oe_n_o), 1);
    end
    full_i = 1'b0;
    drain();
    chk("t3_nwords", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t3_w0", 32'(got_q[0]), 32'h333231);
      chk("t3_w1", 32'(got_q[1]), 32'h363534);
    end

    // 4: resync coincident with the second byte
    got_q.delete();
    src.push_back(8'h01);
    push3(8'h02, 8'h03, 8'h04);
    wait_pend(1, "t4_reach");
    resync_i = 1'b1;
    tick();
    drain();
    chk("t4_nwords", got_q.size(), 1);
    if (got_q.size() == 1) chk("t4_w", 32'(got_q[0]), 32'h040302);

    // 5: asynchronous reset with two bytes pending
    push3(8'h51, 8'h52, 8'h53);
    wait_pend(2, "t5_reach");
    #2 rst_n_i = 1'b0;
    #1;
    chk("t5_oe", 32'(ftdi_oe_n_o), 1);
    chk("t5_rd", 32'(ftdi_rd_n_o), 1);
    chk("t5_we", 32'(f2a_we_o), 0);
    chk("t5_data", 32'(f2a_data_o), 0);
    chk("t5_cnt", 32'(word_cnt_o), 0);
    pend.delete(); exp_q.delete(); got_q.delete(); src.delete();
    we_due = 1'b0; mcnt = 16'd0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    push3(8'hA1, 8'hA2, 8'hA3);
    drain();
    chk("t5_nwords", got_q.size(), 1);
    if (got_q.size() == 1) chk("t5_w", 32'(got_q[0]), 32'hA3A2A1);
    chk("t5_cnt_after", 32'(word_cnt_o), 1);
    chk("left_exp", exp_q.size(), 0);

    // 6: 65536 words of a byte-counter pattern on the byte-wide instance
    w_rxf_n = 1'b0;
    sent = 0;
    seen = 0;
    for (int i = 0; i < 70000 && seen < 65536; i++) begin
      w_data = 8'(sent);
      acc = (w_rd_n === 1'b0);
      @(posedge clk_i);
      @(negedge clk_i);
      if (acc) sent++;
      if (w_we === 1'b1) begin
        chk("t6_data", 32'(w_f2a_data), 32'(seen & 8'hFF));
        seen++;
        if (seen == 65535) chk("t6_cnt_max", 32'(w_cnt), 32'hFFFF);
        if (seen == 65536) chk("t6_wrap", 32'(w_cnt), 0);
      end
    end
    w_rxf_n = 1'b1;
    chk("t6_words", seen, 65536);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
